// File: rtl/dab_wave_meter_if.sv
// dab_wave_meter_if: stimulus/enable inputs and measurement results of the DAB wave meter.
interface dab_wave_meter_if #(
    parameter int CNT_W = 19
);
    logic                    CE;
    logic [1:0]              V1;
    logic [1:0]              V2;
    logic                    err_clr;
    logic [CNT_W-1:0]        period_cnt;
    logic [CNT_W-1:0]        tau1_cnt;
    logic [CNT_W-1:0]        tau2_cnt;
    logic signed [CNT_W-1:0] phi_cnt;
    logic                    meas_valid;
    logic [2:0]              err;
    logic                    sym_err;
    modport master (
        output CE, V1, V2, err_clr,
        input  period_cnt, tau1_cnt, tau2_cnt, phi_cnt, meas_valid, err, sym_err
    );
    modport slave (
        input  CE, V1, V2, err_clr,
        output period_cnt, tau1_cnt, tau2_cnt, phi_cnt, meas_valid, err, sym_err
    );
endinterface

// File: rtl/dab_wave_meter.sv
// dab_wave_meter: recovers period, V1/V2 +1 widths and V2-to-V1 phase from 3-level bridge voltages.
// Define SYM_CHECK_EN to measure the V1 -1 width and flag +/- asymmetry on sym_err.
module dab_wave_meter #(
    parameter int CNT_W   = 19,
    parameter int TIMEOUT = 200000
) (
    input logic             clk,
    input logic             rst,
    dab_wave_meter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MEAS, CALC} state_t;
    localparam logic [1:0]       POS = 2'b01;
    localparam logic [1:0]       NEG = 2'b11;
    localparam logic [1:0]       BAD = 2'b10;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic [1:0]       v1_q, v1p_q, v2_q, v2p_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt2_q, tau2_raw_q;
    logic [CNT_W-1:0] tau1_raw_q, tau1_raw_d, d_raw_q, d_raw_d, d_last_q, d_last_d;
    logic [CNT_W-1:0] period_raw_q, period_raw_d;
    logic [CNT_W-1:0] period_q, period_d, tau1_q, tau1_d, tau2_q, tau2_d, phi_q, phi_d;
    logic             v2_seen_q, v2_seen_d, seen_last_q, seen_last_d, mv_q;
    logic [2:0]       err_q, err_d, err_set;
    logic             r1, f1, r2, f2, run;

    assign r1  = v1_q == POS && v1p_q != POS;
    assign f1  = v1p_q == POS && v1_q != POS;
    assign r2  = v2_q == POS && v2p_q != POS;
    assign f2  = v2p_q == POS && v2_q != POS;
    assign run = state_q != IDLE;

    // A V1 rise closes the period: snapshot the phase capture so a V2 rise on the same
    // cycle can belong to the new period without corrupting the result being published.
    always_comb begin
        state_d      = state_q;
        cnt_d        = run ? cnt_q + ONE : cnt_q;
        tau1_raw_d   = f1 && run ? cnt_q : tau1_raw_q;
        d_raw_d      = r2 && run ? cnt_q : d_raw_q;
        v2_seen_d    = v2_seen_q | (r2 && run);
        d_last_d     = d_last_q;
        seen_last_d  = seen_last_q;
        period_raw_d = period_raw_q;
        period_d     = period_q;
        tau1_d       = tau1_q;
        tau2_d       = tau2_q;
        phi_d        = phi_q;
        err_set      = {1'b0, v1_q == BAD || v2_q == BAD, 1'b0};
        if (r1) begin
            cnt_d        = ONE;
            d_raw_d      = '0;
            v2_seen_d    = r2;
            state_d      = run ? CALC : MEAS;
            period_raw_d = run ? cnt_q : period_raw_q;
            d_last_d     = run ? (r2 ? '0 : d_raw_q) : d_last_q;
            seen_last_d  = run ? v2_seen_q | r2 : seen_last_q;
        end else if (run && cnt_q == TMO) begin
            err_set[0] = 1'b1;
            state_d    = IDLE;
        end else if (state_q == CALC) begin
            state_d = MEAS;
        end
        if (state_q == CALC) begin
            period_d   = period_raw_q;
            tau1_d     = tau1_raw_q;
            tau2_d     = seen_last_q ? tau2_raw_q : tau2_q;
            phi_d      = !seen_last_q ? phi_q :
                         d_last_q <= (period_raw_q >> 1) ? d_last_q : d_last_q - period_raw_q;
            err_set[2] = !seen_last_q;
        end
        err_d = (bus.err_clr ? 3'b000 : err_q) | err_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            v1_q         <= '0;
            v1p_q        <= '0;
            v2_q         <= '0;
            v2p_q        <= '0;
            cnt_q        <= '0;
            cnt2_q       <= '0;
            tau2_raw_q   <= '0;
            tau1_raw_q   <= '0;
            d_raw_q      <= '0;
            d_last_q     <= '0;
            period_raw_q <= '0;
            period_q     <= '0;
            tau1_q       <= '0;
            tau2_q       <= '0;
            phi_q        <= '0;
            v2_seen_q    <= 1'b0;
            seen_last_q  <= 1'b0;
            mv_q         <= 1'b0;
            err_q        <= '0;
        end else if (bus.CE) begin
            state_q      <= state_d;
            v1_q         <= bus.V1;
            v1p_q        <= v1_q;
            v2_q         <= bus.V2;
            v2p_q        <= v2_q;
            cnt_q        <= cnt_d;
            cnt2_q       <= r2 ? ONE : cnt2_q + ONE;
            tau2_raw_q   <= f2 ? cnt2_q : tau2_raw_q;
            tau1_raw_q   <= tau1_raw_d;
            d_raw_q      <= d_raw_d;
            d_last_q     <= d_last_d;
            period_raw_q <= period_raw_d;
            period_q     <= period_d;
            tau1_q       <= tau1_d;
            tau2_q       <= tau2_d;
            phi_q        <= phi_d;
            v2_seen_q    <= v2_seen_d;
            seen_last_q  <= seen_last_d;
            mv_q         <= state_q == CALC;
            err_q        <= err_d;
        end
    end

`ifdef SYM_CHECK_EN
    logic [CNT_W-1:0] cnt3_q, neg_raw_q, sdiff;
    logic             sym_q;
    assign sdiff = neg_raw_q - tau1_raw_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt3_q    <= '0;
            neg_raw_q <= '0;
            sym_q     <= 1'b0;
        end else if (bus.CE) begin
            cnt3_q    <= v1_q == NEG && v1p_q != NEG ? ONE : cnt3_q + ONE;
            neg_raw_q <= v1p_q == NEG && v1_q != NEG ? cnt3_q : neg_raw_q;
            sym_q     <= state_q == CALC ? !(sdiff == '0 || sdiff == ONE || &sdiff) : sym_q;
        end
    end
    assign bus.sym_err = sym_q;
`else
    assign bus.sym_err = 1'b0;
`endif

    assign bus.period_cnt = period_q;
    assign bus.tau1_cnt   = tau1_q;
    assign bus.tau2_cnt   = tau2_q;
    assign bus.phi_cnt    = phi_q;
    assign bus.meas_valid = mv_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_dab_wave_meter.sv
// tb_dab_wave_meter: directed waveforms for the DAB wave meter with hand-computed expectations.
module tb_dab_wave_meter;
    localparam int CNT_W = 19;
    localparam int TMO   = 3000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dab_wave_meter_if #(.CNT_W(CNT_W)) bus ();
    dab_wave_meter #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0, errors = 0;
    int P = 1000, wp = 300, wn = 300, d2 = 50;
    int ph = -1, nstb = 0, stb_ph = 0, gap = 0, n0 = 0;
    bit v1_en = 1'b1, v2_en = 1'b1, mv_last = 1'b0;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_meas(input string tag, input int per, input int t1, input int t2,
                            input int phi, input int e);
        check({tag, ".period"}, bus.period_cnt, per);
        check({tag, ".tau1"}, bus.tau1_cnt, t1);
        check({tag, ".tau2"}, bus.tau2_cnt, t2);
        check({tag, ".phi"}, bus.phi_cnt, phi);
        check({tag, ".err"}, bus.err, e);
    endtask

    // +1 for [0,wp), -1 for [P/2,P/2+wn), else 0, within each period
    function automatic logic [1:0] lvl(input int p);
        int m = ((p % P) + P) % P;
        return m < wp ? 2'b01 : (m >= P / 2 && m < P / 2 + wn) ? 2'b11 : 2'b00;
    endfunction

    // ph counts CE cycles only, so a stall freezes the waveform in place
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.meas_valid && !mv_last) begin
                nstb++;
                gap    = ph - stb_ph;
                stb_ph = ph;
            end
            mv_last = bus.meas_valid;
            if (bus.CE) begin
                ph++;
                bus.V1 = v1_en ? lvl(ph) : 2'b00;
                bus.V2 = v2_en ? lvl(ph - d2) : 2'b00;
            end
        end
    endtask

    task automatic align(input int p);
        for (int i = 0; i < 2 * P && (ph % P) != p; i++) run(1);
    endtask

    task automatic clr;
        bus.err_clr = 1'b1;
        run(1);
        bus.err_clr = 1'b0;
        run(2);
    endtask

    initial begin
        bus.CE = 1'b1;
        bus.V1 = 2'b00;
        bus.V2 = 2'b00;
        bus.err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk_meas("reset", 0, 0, 0, 0, 0);
        check("reset.valid", bus.meas_valid, 0);
        check("reset.sym", bus.sym_err, 0);
        rst = 1'b1;

        run(2500);
        check("lock.nstb", nstb, 2);
        chk_meas("lock", 1000, 300, 300, 50, 0);
        check("lock.gap", gap, 1000);
        check("lock.latency", stb_ph % P, 2);

        align(400); d2 = -17; run(2000);
        chk_meas("advance", 1000, 300, 300, -17, 0);
        align(400); d2 = 500; run(2000);
        check("phi_half", bus.phi_cnt, 500);
        align(400); d2 = 501; run(2000);
        check("phi_half_plus1", bus.phi_cnt, -499);
        align(400); d2 = 50; run(2000);
        check("phi_back", bus.phi_cnt, 50);

        align(400); v2_en = 1'b0; run(1700);
        chk_meas("v2_missing", 1000, 300, 300, 50, 4);
        align(990); v2_en = 1'b1; run(1200);
        clr;
        check("v2_clr.err", bus.err, 0);

        align(400); bus.V1 = 2'b10; run(3);
        check("illegal.err", bus.err, 2);
        clr;
        check("illegal_clr.err", bus.err, 0);
        run(1000);
        check("illegal.period", bus.period_cnt, 1000);
        check("illegal.err_after", bus.err, 0);

        align(400); v1_en = 1'b0; n0 = nstb; run(3000);
        check("timeout.err", bus.err, 1);
        check("timeout.nstb", nstb, n0);
        align(500); v1_en = 1'b1; run(1000);
        check("rearm1.nstb", nstb, n0);
        run(1000);
        check("rearm2.nstb", nstb, n0 + 1);
        chk_meas("rearm", 1000, 300, 300, 50, 1);
        clr;
        check("rearm_clr.err", bus.err, 0);

        align(500);
        rst = 1'b0;
        #1;
        chk_meas("async_rst", 0, 0, 0, 0, 0);
        check("async_rst.valid", bus.meas_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        n0 = nstb;
        run(1000);
        check("post_rst1.nstb", nstb, n0);
        run(1000);
        check("post_rst2.nstb", nstb, n0 + 1);
        chk_meas("post_rst", 1000, 300, 300, 50, 0);

        align(100); bus.CE = 1'b0; run(100); bus.CE = 1'b1; run(1000);
        chk_meas("ce_stall", 1000, 300, 300, 50, 0);
        check("ce_stall.gap", gap, 1000);

`ifdef SYM_CHECK_EN
        align(400); wn = 303; run(2000);
        check("sym_wide", bus.sym_err, 1);
        align(400); wn = 301; run(2000);
        check("sym_ok", bus.sym_err, 0);
        check("sym_ok.tau1", bus.tau1_cnt, 300);
`else
        check("sym_off", bus.sym_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dab_wave_meter.md
Name: dab_wave_meter

Overview:
- Measurement counterpart of the DAB V1/V2 voltage-pattern generator.
- Samples the 3-level bridge voltages V1 and V2 (+1/0/-1) and recovers, in clock counts, the switching period, the V1 positive-pulse width (tau1), the V2 positive-pulse width (tau2) and the signed V2-to-V1 phase shift (phi).
- Used for closed-loop readback and bench self-check of the modulator. Results publish once per V1 period with a valid strobe.

Parameters:
- CNT_W, 19, width of all count outputs and internal counters (signed, two's complement).
- TIMEOUT, 200000, counts without a V1 rising event before measurement aborts; must be ≤ 2^(CNT_W-1)-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- CE  in  1  clock enable; all state, counters and input samplers advance only when CE=1
- V1  in  2  signed primary voltage level: 2'b01=+1, 2'b00=0, 2'b11=-1
- V2  in  2  signed secondary voltage level, same coding
- err_clr  in  1  synchronous clear of sticky err bits
- period_cnt  out  CNT_W  measured V1 period in counts
- tau1_cnt  out  CNT_W  V1 +1 pulse width
- tau2_cnt  out  CNT_W  V2 +1 pulse width
- phi_cnt  out  CNT_W  signed shift of V2 +1 entry relative to V1 +1 entry, range (-P/2, P/2]
- meas_valid  out  1  one-CE-cycle strobe: outputs updated
- err  out  3  sticky: [0] timeout, [1] illegal code 2'b10 on V1 or V2, [2] no V2 rise in last period
- sym_err  out  1  see Optional Feature

Behaviour:
- Reset (rst=0, async): all outputs 0; state IDLE; samplers reset to level 0.
- Input stage: V1/V2 registered once (v1_q, v2_q), plus one previous-sample register each. Events are defined on registered samples only:
  - r1: v1_q=+1 and v1_prev≠+1
  - f1: v1_prev=+1 and v1_q≠+1
  - r2, f2: same definitions for V2
- Main counter cnt: the r1 cycle counts as 0; cnt is loaded to 1 on that cycle and increments each CE cycle in MEAS and CALC. A value captured at any later event equals the cycles elapsed since r1.
- States:
  - IDLE → MEAS on r1. All other events are ignored in IDLE.
  - MEAS:
    - f1: tau1_raw <= cnt.
    - r2: d_raw <= cnt and v2_seen <= 1. If r2 coincides with r1, d_raw = 0.
    - r1: period_raw <= cnt, cnt <= 1, go CALC.
    - cnt = TIMEOUT without r1: err[0] <= 1, go IDLE, no strobe.
  - CALC (exactly 1 cycle):
    - phi_cnt = d_raw if d_raw ≤ period_raw>>1, else d_raw - period_raw.
    - Load period_cnt, tau1_cnt, tau2_cnt, phi_cnt; meas_valid=1.
    - If v2_seen=0: err[2] <= 1, and phi_cnt/tau2_cnt keep their previous values.
    - Clear v2_seen, then go MEAS. Events arriving in the CALC cycle are processed as in MEAS.
- tau2 counter cnt2 runs independently: loaded to 1 on r2, tau2_raw <= cnt2 on f2. This lets V2 pulses span a V1 boundary.
- Latency: meas_valid asserts 2 CE cycles after the V1 +1 level reaches the V1 pin (sampler, then CALC).
- First r1 after reset, timeout, or IDLE produces no strobe. The first strobe follows the second r1.
- Illegal code 2'b10 on either input sets err[1] and is treated as level 0.
- Direct +1 to -1 transitions are legal and generate f1 normally.
- err_clr clears all err bits. If err_clr coincides with a set condition, the set wins.
- CE=0 freezes everything, including the samplers.
- Minimum supported pulse or gap: 2 cycles.

Optional Feature:
- Macro: SYM_CHECK_EN.
- Defined:
  - A third counter measures the V1 -1 pulse width.
  - In CALC, sym_err is registered to 1 if |neg_width - tau1_raw| > 1, else 0.
  - sym_err updates only on strobes.
- Undefined: sym_err is tied to 0 and the counter is not built.

Test Plan:
- V1 period 1000, +1 width 300, -1 width 300, V2 identical but delayed 50 → from the 2nd strobe on: period=1000, tau1=300, tau2=300, phi=+50, err=0, strobes every 1000 cycles.
- Same stimulus, V2 advanced 17 (generator default phi) → phi=-17 (captured d=983 > 500, so 983-1000).
- V2 held at 0 for one full period → strobe with err[2]=1, phi/tau2 unchanged; err_clr pulse → err=0.
- V1 stuck at 0 after lock → after TIMEOUT=200000 counts, err[0]=1, state IDLE, no further strobes until two r1 events.
- rst pulsed low mid-period, and separately CE low for 100 cycles mid-pulse → reset: outputs 0 immediately and first strobe after 2nd r1; CE stall: all measured counts unchanged vs. the CE=1 run.
- SYM_CHECK_EN defined, -1 width 303 vs +1 width 300 → sym_err=1; -1 width 301 → sym_err=0.
